// File: rtl/aes_block_loader.sv
// aes_block_loader: assembles a 128-bit plaintext block and a 128-bit key
// from a byte-serial stream and presents them together as one pair.
//
// Handshakes: upstream bytes move on a rising edge with in_valid=1 and
// in_ready=1; the assembled pair moves on a rising edge with out_valid=1
// and out_ready=1. in_ready and out_valid are registers that depend only
// on the state, never combinationally on in_valid, in_sel or out_ready.
module aes_block_loader #(
    parameter int KEY_REUSE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_text,
    output logic [127:0] key,
    output logic         err
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [4:0]  pcnt;
    logic [4:0]  kcnt;

    logic        accept;
    logic        p_full;
    logic        k_full;
    logic        take_p;
    logic        take_k;
    logic        overflow;
    logic [4:0]  pcnt_nxt;
    logic [4:0]  kcnt_nxt;
    logic        done;
    logic [6:0]  p_lo;
    logic [6:0]  k_lo;

    // Accept/overflow decode and the low bit position of the next byte
    // slot; the first byte of a buffer lands in the top byte (MSB-first).
    always_comb begin
        accept   = in_valid & in_ready;
        p_full   = (pcnt == 5'd16);
        k_full   = (kcnt == 5'd16);
        take_p   = accept & ~in_sel & ~p_full;
        take_k   = accept &  in_sel & ~k_full;
        overflow = accept & ((in_sel & k_full) | (~in_sel & p_full));
        pcnt_nxt = pcnt + {4'd0, take_p};
        kcnt_nxt = kcnt + {4'd0, take_k};
        done     = (take_p | take_k) & (pcnt_nxt == 5'd16) & (kcnt_nxt == 5'd16);
        p_lo     = 7'd120 - {pcnt[3:0], 3'b000};
        k_lo     = 7'd120 - {kcnt[3:0], 3'b000};
    end

    // FILL/HOLD controller with registered handshake outputs, byte counters,
    // buffers and the sticky overflow flag. Buffers are not cleared when a
    // counter clears; new bytes simply overwrite the stale ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            pcnt       <= 5'd0;
            kcnt       <= 5'd0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            plain_text <= 128'd0;
            key        <= 128'd0;
        end else begin
            case (state)
                FILL: begin
                    // in_ready rises on the first edge after reset release.
                    in_ready <= 1'b1;
                    if (take_p) begin
                        plain_text[p_lo +: 8] <= in_byte;
                        pcnt                  <= pcnt_nxt;
                    end
                    if (take_k) begin
                        key[k_lo +: 8] <= in_byte;
                        kcnt           <= kcnt_nxt;
                    end
                    if (overflow) begin
                        err <= 1'b1;
                    end
                    if (done) begin
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // Offered bytes are ignored here; the pair stays frozen.
                    if (out_ready) begin
                        state     <= FILL;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        pcnt      <= 5'd0;
                        if (KEY_REUSE == 0) begin
                            kcnt <= 5'd0;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: two instances (KEY_REUSE=1 and KEY_REUSE=0)
// share one input stream; a queue-level model per instance predicts every
// output each cycle, and directed phases pin the model with literal blocks.
`timescale 1ns/1ps
module tb_aes_block_loader;

    localparam logic [127:0] K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] Q = 128'h00112233445566778899aabbccddeeff;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic [7:0]   in_byte = 8'd0;
    logic         in_sel = 1'b0;
    logic         out_ready = 1'b0;

    logic         r_in_ready, r_out_valid, r_err;
    logic [127:0] r_plain, r_key;
    logic         n_in_ready, n_out_valid, n_err;
    logic [127:0] n_plain, n_key;

    aes_block_loader #(.KEY_REUSE(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
        .in_byte(in_byte), .in_sel(in_sel), .out_valid(r_out_valid),
        .out_ready(out_ready), .plain_text(r_plain), .key(r_key), .err(r_err)
    );

    aes_block_loader #(.KEY_REUSE(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_byte(in_byte), .in_sel(in_sel), .out_valid(n_out_valid),
        .out_ready(out_ready), .plain_text(n_plain), .key(n_key), .err(n_err)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Index 1 models the KEY_REUSE=1 instance, index 0 the KEY_REUSE=0 one.
    // Each buffer is a list of received bytes; a pair is complete when both
    // lists hold 16 bytes, and a byte for a full list is an overflow.
    logic [7:0]   m_pb [2][16];
    logic [7:0]   m_kb [2][16];
    int           m_pn [2] = '{0, 0};
    int           m_kn [2] = '{0, 0};
    bit           m_hold [2] = '{0, 0};
    bit           m_err [2] = '{0, 0};
    bit           m_up [2] = '{0, 0};
    logic [127:0] m_pt [2] = '{128'd0, 128'd0};
    logic [127:0] m_key [2] = '{128'd0, 128'd0};

    function automatic logic [127:0] pack16(input logic [7:0] b [16]);
        logic [127:0] v = 128'd0;
        for (int j = 0; j < 16; j++) v = {v[119:0], b[j]};
        return v;
    endfunction

    always begin
        @(posedge clk or negedge rst_n);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_pn[i] = 0; m_kn[i] = 0; m_hold[i] = 0; m_err[i] = 0; m_up[i] = 0;
                m_pt[i] = 128'd0; m_key[i] = 128'd0;
            end else begin
                if (m_hold[i]) begin
                    if (out_ready) begin
                        m_hold[i] = 0;
                        m_pn[i] = 0;
                        if (i == 0) m_kn[i] = 0;
                    end
                end else if (m_up[i] && in_valid) begin
                    if (in_sel) begin
                        if (m_kn[i] == 16) m_err[i] = 1;
                        else begin m_kb[i][m_kn[i]] = in_byte; m_kn[i]++; end
                    end else begin
                        if (m_pn[i] == 16) m_err[i] = 1;
                        else begin m_pb[i][m_pn[i]] = in_byte; m_pn[i]++; end
                    end
                    if (m_pn[i] == 16 && m_kn[i] == 16) begin
                        m_hold[i] = 1;
                        m_pt[i] = pack16(m_pb[i]);
                        m_key[i] = pack16(m_kb[i]);
                    end
                end
                m_up[i] = 1;
            end
        end
    end

    // ---------------- scoreboard: every negedge ----------------
    task automatic cmp_inst(input int i, input logic rdy, input logic vld, input logic e,
                            input logic [127:0] pt, input logic [127:0] k);
        chk($sformatf("in_ready[%0d]", i), rdy, m_up[i] && !m_hold[i]);
        chk($sformatf("out_valid[%0d]", i), vld, m_hold[i]);
        chk($sformatf("err[%0d]", i), e, m_err[i]);
        if (!rst_n) begin
            chk($sformatf("plain_rst[%0d]", i), pt, 128'd0);
            chk($sformatf("key_rst[%0d]", i), k, 128'd0);
        end else if (m_hold[i]) begin
            chk($sformatf("plain[%0d]", i), pt, m_pt[i]);
            chk($sformatf("key[%0d]", i), k, m_key[i]);
        end
    endtask

    always begin
        @(negedge clk);
        cmp_inst(1, r_in_ready, r_out_valid, r_err, r_plain, r_key);
        cmp_inst(0, n_in_ready, n_out_valid, n_err, n_plain, n_key);
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic send(input bit sel, input logic [7:0] b);
        in_valid = 1'b1; in_sel = sel; in_byte = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input bit sel, input logic [127:0] v);
        for (int j = 0; j < 16; j++) send(sel, v[127 - 8*j -: 8]);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin @(posedge clk); #1; end
    endtask

    // Handshake edge with a byte offered on the same edge.
    task automatic handshake();
        out_ready = 1'b1; in_valid = 1'b1;
        in_sel = 1'($urandom_range(0, 1)); in_byte = 8'($urandom);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_first_cycle", r_in_ready, 1'b0);
        @(posedge clk); #1;
        chk("ready_after_edge", r_in_ready, 1'b1);
        chk("ready_after_edge_n", n_in_ready, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", r_out_valid, 1'b0);
        chk("reset_ready", r_in_ready, 1'b0);
        chk("reset_key", r_key, 128'd0);
        release_reset();

        // Basic load: key then plaintext.
        send_block(1'b1, K);
        send_block(1'b0, P);
        chk("a_valid", r_out_valid, 1'b1);
        chk("a_valid_n", n_out_valid, 1'b1);
        chk("a_key", r_key, K);
        chk("a_plain", r_plain, P);
        chk("a_ready", r_in_ready, 1'b0);
        chk("a_err", r_err, 1'b0);
        chk("model_key", m_key[1], K);
        chk("model_plain", m_pt[1], P);

        // Backpressure with bytes offered while holding.
        for (int c = 0; c < 10; c++) begin
            in_valid = (c % 3 == 0); in_sel = 1'($urandom_range(0, 1)); in_byte = 8'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_valid", r_out_valid, 1'b1);
            chk("bp_ready", r_in_ready, 1'b0);
            chk("bp_key", r_key, K);
            chk("bp_plain", r_plain, P);
            chk("bp_err", r_err, 1'b0);
        end
        handshake();
        chk("hs_valid", r_out_valid, 1'b0);
        chk("hs_ready", r_in_ready, 1'b1);

        // Key reuse: plaintext only.
        send_block(1'b0, Q);
        chk("reuse_valid", r_out_valid, 1'b1);
        chk("reuse_key", r_key, K);
        chk("reuse_plain", r_plain, Q);
        chk("noreuse_valid", n_out_valid, 1'b0);
        send_block(1'b1, K);
        chk("noreuse_valid2", n_out_valid, 1'b1);
        chk("noreuse_key", n_key, K);
        chk("noreuse_plain", n_plain, Q);
        chk("reuse_still", r_plain, Q);
        chk("reuse_err", r_err, 1'b0);
        handshake();

        // Interleaved load.
        for (int j = 0; j < 16; j++) begin
            send(1'b1, K[127 - 8*j -: 8]);
            send(1'b0, P[127 - 8*j -: 8]);
        end
        chk("il_valid_n", n_out_valid, 1'b1);
        chk("il_key_n", n_key, K);
        chk("il_plain_n", n_plain, P);
        chk("il_err_n", n_err, 1'b0);
        chk("il_valid_r", r_out_valid, 1'b1);
        chk("il_key_r", r_key, K);
        chk("il_err_r", r_err, 1'b1);
        handshake();

        // Explicit overflow with kcnt held at 16.
        send(1'b1, 8'haa);
        chk("ovf_err", r_err, 1'b1);
        send_block(1'b0, Q);
        chk("ovf_valid", r_out_valid, 1'b1);
        chk("ovf_key", r_key, K);
        handshake();
        chk("ovf_err_sticky", r_err, 1'b1);

        // Reset mid-fill.
        for (int j = 0; j < 7; j++) send(1'b1, K[127 - 8*j -: 8]);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_ready", r_in_ready, 1'b0);
        chk("mr_valid", r_out_valid, 1'b0);
        chk("mr_err", r_err, 1'b0);
        chk("mr_key", r_key, 128'd0);
        chk("mr_plain", r_plain, 128'd0);
        chk("mr_key_n", n_key, 128'd0);
        @(posedge clk); #1;
        release_reset();
        send_block(1'b1, K);
        send_block(1'b0, P);
        chk("mr2_valid", r_out_valid, 1'b1);
        chk("mr2_key", r_key, K);
        chk("mr2_plain", r_plain, P);
        chk("mr2_key_n", n_key, K);
        chk("mr2_plain_n", n_plain, P);
        chk("mr2_err", r_err, 1'b0);
        handshake();

        // Random traffic against the model, with occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel = 1'($urandom_range(0, 1));
            in_byte = 8'($urandom);
            out_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
